pwm_gen: RTL and testbench



---
 rtl/pwm_gen.sv | 57 +++++
 tb/tb_pwm_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - single-channel edge-aligned PWM generator, 32-bit counter
// Define PWM_PRELOAD_EN for shadowed period/compare registers updated at the period boundary.
`timescale 1ns/1ps
module pwm_gen (
  input  logic        Clk50M,
  input  logic        Rst_n,
  input  logic        cnt_en,
  input  logic [31:0] counter_arr,
  input  logic [31:0] counter_ccr,
  output logic        o_pwm
);

  logic [31:0] cnt;
  logic [31:0] arr_act;
  logic [31:0] ccr_act;

`ifdef PWM_PRELOAD_EN
  logic [31:0] arr_sh;
  logic [31:0] ccr_sh;

  // Shadows track the inputs while stopped and latch them again on the wrap edge.
  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      arr_sh <= '0;
      ccr_sh <= '0;
    end else if (!cnt_en || (cnt >= arr_sh)) begin
      arr_sh <= counter_arr;
      ccr_sh <= counter_ccr;
    end
  end

  assign arr_act = arr_sh;
  assign ccr_act = ccr_sh;
`else
  assign arr_act = counter_arr;
  assign ccr_act = counter_ccr;
`endif

  // The >= wrap keeps cnt bounded even if the active period shrinks below it.
  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt   <= '0;
      o_pwm <= 1'b0;
    end else if (!cnt_en) begin
      cnt   <= '0;
      o_pwm <= 1'b0;
    end else begin
      o_pwm <= (cnt < ccr_act);
      if (cnt >= arr_act) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen (table vectors, directed corners, random vs model)
// Model follows PWM_PRELOAD_EN the same way the design does.
`timescale 1ns/1ps
module tb_pwm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] arr;
  logic [31:0] ccr;
  logic        pwm;

  int checks = 0;
  int errors = 0;

  bit          wave[$];
  logic [31:0] pend_arr;
  logic [31:0] pend_ccr;
  logic [31:0] pos;
  bit          exp_pwm;

  typedef struct {
    logic [31:0] arr;
    logic [31:0] ccr;
    int          cycles;
    int          highs;
  } vec_t;

  vec_t vecs[9];

  pwm_gen dut (
    .Clk50M      (clk),
    .Rst_n       (rst_n),
    .cnt_en      (en),
    .counter_arr (arr),
    .counter_ccr (ccr),
    .o_pwm       (pwm)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Preload build: each period is a precomputed waveform (ccr ones, then zeros, arr+1 long)
  // built from the settings captured at the edge that ended the previous period or while stopped.
  task automatic model_edge();
    if (!rst_n) begin
      wave.delete();
      pend_arr = '0;
      pend_ccr = '0;
      pos      = '0;
      exp_pwm  = 1'b0;
      return;
    end
`ifdef PWM_PRELOAD_EN
    if (!en) begin
      wave.delete();
      exp_pwm  = 1'b0;
      pend_arr = arr;
      pend_ccr = ccr;
    end else begin
      if (wave.size() == 0)
        for (longint i = 0; i <= longint'(pend_arr); i++)
          wave.push_back(i < longint'(pend_ccr));
      exp_pwm = wave.pop_front();
      if (wave.size() == 0) begin
        pend_arr = arr;
        pend_ccr = ccr;
      end
    end
`else
    if (!en) begin
      pos     = '0;
      exp_pwm = 1'b0;
    end else begin
      exp_pwm = (pos < ccr);
      pos     = (pos >= arr) ? 32'd0 : pos + 32'd1;
    end
`endif
  endtask

  task automatic step(input string name);
    model_edge();
    @(posedge clk);
    #1;
    check(name, {31'd0, pwm}, {31'd0, exp_pwm});
  endtask

  task automatic run_count(input string name, input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      step(name);
      if (pwm === 1'b1) highs++;
    end
  endtask

  initial begin
    int h;
    int h2;

    vecs[0] = '{arr: 32'd999, ccr: 32'd400,  cycles: 2000, highs: 800};
    vecs[1] = '{arr: 32'd499, ccr: 32'd250,  cycles: 1000, highs: 500};
    vecs[2] = '{arr: 32'd499, ccr: 32'd100,  cycles: 1000, highs: 200};
    vecs[3] = '{arr: 32'd999, ccr: 32'd0,    cycles: 1000, highs: 0};
    vecs[4] = '{arr: 32'd999, ccr: 32'd1200, cycles: 1000, highs: 1000};
    vecs[5] = '{arr: 32'd0,   ccr: 32'd1,    cycles: 50,   highs: 50};
    vecs[6] = '{arr: 32'd0,   ccr: 32'd0,    cycles: 50,   highs: 0};
    vecs[7] = '{arr: 32'd9,   ccr: 32'd10,   cycles: 20,   highs: 20};
    vecs[8] = '{arr: 32'd9,   ccr: 32'd9,    cycles: 20,   highs: 18};

    rst_n = 1'b0;
    en    = 1'b0;
    arr   = '0;
    ccr   = '0;
    model_edge();

    // reset held with arbitrary inputs
    for (int k = 0; k < 20; k++) begin
      en  = 1'($urandom);
      arr = 32'($urandom_range(0, 20));
      ccr = 32'($urandom_range(0, 25));
      step("reset_hold");
    end
    en    = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("idle_after_reset");

    // table: fresh enable, count high cycles over whole periods
    for (int v = 0; v < 9; v++) begin
      en  = 1'b0;
      arr = vecs[v].arr;
      ccr = vecs[v].ccr;
      step("table_disable");
      step("table_disable");
      en = 1'b1;
      step($sformatf("first_edge%0d", v));
      h = (pwm === 1'b1) ? 1 : 0;
      run_count($sformatf("table%0d", v), vecs[v].cycles - 1, h2);
      check($sformatf("highs%0d", v), 32'(h + h2), 32'(vecs[v].highs));
    end

    // compare change mid-period
    en  = 1'b0;
    arr = 32'd999;
    ccr = 32'd400;
    step("ccr_change_dis");
    en = 1'b1;
    run_count("ccr_change_a", 500, h);
    ccr = 32'd700;
    run_count("ccr_change_b", 500, h2);
`ifdef PWM_PRELOAD_EN
    check("ccr_change_p1", 32'(h + h2), 32'd400);
`else
    check("ccr_change_p1", 32'(h + h2), 32'd600);
`endif
    run_count("ccr_change_p2", 1000, h);
    check("ccr_change_p2_highs", 32'(h), 32'd700);

    // disable during the high phase
    run_count("dis_high_run", 100, h);
    check("dis_high_before", {31'd0, pwm}, 32'd1);
    en = 1'b0;
    step("dis_high_next_edge");
    check("dis_high_low", {31'd0, pwm}, 32'd0);

    // randomized against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) arr = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ccr = 32'($urandom_range(0, 20));
      en = ($urandom_range(0, 15) != 0);
      step("random");
    end

    // asynchronous reset mid-period
    en  = 1'b0;
    arr = 32'd99;
    ccr = 32'd50;
    step("areset_setup");
    en = 1'b1;
    run_count("areset_run", 10, h);
    check("areset_high_before", {31'd0, pwm}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("areset_async_low", {31'd0, pwm}, 32'd0);
    for (int k = 0; k < 3; k++) step("areset_hold");
    rst_n = 1'b1;
    en    = 1'b0;
    step("areset_release");
    en = 1'b1;
    run_count("areset_restart", 100, h);
    check("areset_restart_highs", 32'(h), 32'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
